mips_prog_loader: RTL and testbench
===================================

# mips_prog_loader

Single-clock host-side controller for the MIPS32 pipeline. It accepts a stream of instruction words and writes them into instruction memory from address 0. It then releases the core from a clean initial state and waits for the core to report HALTED. Finally it reads back the low registers and streams them out. It replaces hierarchical pokes and peeks as the way programs are loaded and results collected.

## Interface
Parameters:
- MEM_AW, 10: instruction-memory word-address width.
- DUMP_REGS, 6: number of registers dumped, R0..R(DUMP_REGS-1), range 1..32.
- TIMEOUT, 1000: maximum RUN cycles before a forced dump.

Ports:
- clk1  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  program word valid.
- in_ready  out  1  loader accepts a word.
- in_data  in  32  instruction word.
- in_last  in  1  final word of program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  MEM_AW  write word address.
- mem_wdata  out  32  write data.
- core_init  out  1  one-cycle pulse; the core clears PC, HALTED and TAKEN_BRANCH.
- core_run  out  1  core may fetch while high.
- core_halted  in  1  core HALTED flag.
- reg_raddr  out  5  register-file read address.
- reg_rdata  in  32  register-file read data, combinational from reg_raddr.
- out_valid  out  1  dump word valid.
- out_ready  in  1  sink accepts dump word.
- out_data  out  32  dump word.
- out_last  out  1  last dump word.
- done  out  1  sequence complete, sticky.
- timeout  out  1  RUN ended by TIMEOUT, sticky.
- overflow  out  1  memory filled before in_last, sticky.

## Operation
- FSM states: LOAD (reset state), START, RUN, DUMP, DONE.
- LOAD:
  - in_ready=1.
  - On each handshake (in_valid&in_ready), the next cycle has mem_we=1, mem_addr=wptr, mem_wdata=in_data. Then wptr increments.
  - A handshake with in_last=1 goes to START.
  - A handshake at wptr=2^MEM_AW-1 without in_last sets overflow and goes to START; that word is still written.
  - core_run=0 throughout.
- START:
  - core_init=1 for exactly this cycle.
  - in_ready=0.
  - Next state is RUN.
  - The final mem_we pulse coincides with START.
- RUN:
  - core_run=1.
  - The cycle counter starts at 0 on entry and increments every RUN cycle.
  - core_halted=1 goes to DUMP.
  - If the counter reaches TIMEOUT-1 with core_halted=0, set timeout and go to DUMP.
  - core_halted is ignored in START.
- DUMP:
  - core_run=0.
  - out_valid=1, reg_raddr=idx, out_data=reg_rdata.
  - out_last=1 when idx=DUMP_REGS-1.
  - On each handshake idx increments.
  - The handshake with out_last goes to DONE.
  - out_data and reg_raddr must hold while out_ready=0.
- DONE:
  - done=1.
  - All handshakes are deasserted.
  - The FSM stays in DONE until rst.
- in_valid in any state but LOAD is ignored (in_ready=0). Words are never dropped silently inside LOAD.

## Timing
- Reset values:
  - state=LOAD, wptr=0, idx=0.
  - in_ready=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - core_init=0, core_run=0.
  - reg_raddr=0.
  - out_valid=0, out_last=0.
  - done=0, timeout=0, overflow=0.
- Write latency: the handshake in cycle n produces the mem_we pulse in cycle n+1. Back-to-back handshakes give back-to-back writes at consecutive addresses.
- LOAD to START to RUN: core_run rises 2 cycles after the in_last handshake. core_init is high in the cycle between.
- RUN to DUMP: out_valid rises the cycle after core_halted is sampled high.
- Throughput:
  - With out_ready held high, one dump word per cycle.
  - Minimum total dump is DUMP_REGS cycles.
- rst asserted in any state returns all outputs to reset values immediately, without waiting for clk1. A partially loaded program is abandoned. The next load restarts at address 0.
- Address arithmetic: wptr is MEM_AW bits and never wraps; overflow stops the load instead.

## Test plan
- Load the 9 words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last on word 9).
  - Required: mem writes at addr 0..8 with exact data.
  - Required: one core_init pulse, then core_run.
  - Required with a real core: dump R0..R5 = 0, 10, 20, 25, 30, 55.
- Throttled load: in_valid toggles every other cycle.
  - Required: writes stay contiguous at addr 0..8.
  - Required: no duplicate mem_we pulses.
- Stub core that never halts, TIMEOUT=50.
  - Required: timeout=1 exactly 50 cycles after RUN entry.
  - Required: the dump still emits 6 words with out_last on the 6th.
- Sink backpressure: out_ready low 3 cycles per word, stub reg_rdata=0x100+addr.
  - Required: out_data stable while stalled.
  - Required: sequence 0x100..0x105, then done=1.
- MEM_AW=3, 10 words with no in_last.
  - Required: overflow=1 after the 8th word at addr 7; the load ends there.
  - Required: words 9 and 10 are not accepted (in_ready=0).
- rst pulsed mid-load after 4 words, then a fresh 2-word load.
  - Required: all outputs return to reset values asynchronously.
  - Required: the new writes land at addr 0 and 1.

Source files
------------

// File: rtl/mips_prog_loader_if.sv
// Signal bundle between mips_prog_loader and its host stream, instruction
// memory, core control, register file and dump sink.
interface mips_prog_loader_if #(
  parameter int MEM_AW = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_init;
  logic              core_run;
  logic              core_halted;
  logic [4:0]        reg_raddr;
  logic [31:0]       reg_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              done;
  logic              timeout;
  logic              overflow;

  modport master (
    input  in_valid, in_data, in_last, core_halted, reg_rdata, out_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, core_init, core_run,
           reg_raddr, out_valid, out_data, out_last, done, timeout, overflow
  );

  modport slave (
    output in_valid, in_data, in_last, core_halted, reg_rdata, out_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_init, core_run,
           reg_raddr, out_valid, out_data, out_last, done, timeout, overflow
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Host-side loader for the MIPS32 pipeline: streams a program into instruction
// memory, runs the core until HALTED (or timeout), then streams out R0..R(DUMP_REGS-1).
module mips_prog_loader #(
  parameter int MEM_AW    = 10,
  parameter int DUMP_REGS = 6,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clk1,
  input  logic               rst,
  mips_prog_loader_if.master bus
);

  localparam int                CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]     T_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]        R_LAST = 5'(DUMP_REGS - 1);
  localparam logic [MEM_AW-1:0] A_LAST = '1;

  typedef enum logic [2:0] {S_LOAD, S_START, S_RUN, S_DUMP, S_DONE} state_t;

  state_t            state;
  logic [MEM_AW-1:0] wptr;
  logic [4:0]        idx;
  logic [CW-1:0]     cnt;

  // The write pointer parks at the top address; overflow ends the load instead of wrapping.
  function automatic logic [MEM_AW-1:0] sat_inc(input logic [MEM_AW-1:0] a);
    return (a == A_LAST) ? a : a + 1'b1;
  endfunction

  assign bus.reg_raddr = idx;
  assign bus.out_data  = bus.reg_rdata;
  assign bus.out_last  = bus.out_valid & (idx == R_LAST);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state         <= S_LOAD;
      wptr          <= '0;
      idx           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.core_init <= 1'b0;
      bus.core_run  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.mem_we    <= 1'b0;
      bus.core_init <= 1'b0;
      case (state)
        // Accepted word is written one cycle later at the current pointer.
        S_LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wptr;
            bus.mem_wdata <= bus.in_data;
            wptr          <= sat_inc(wptr);
            if (bus.in_last || wptr == A_LAST) begin
              bus.overflow  <= ~bus.in_last;
              bus.in_ready  <= 1'b0;
              bus.core_init <= 1'b1;
              state         <= S_START;
            end
          end
        end
        S_START: begin
          bus.core_run <= 1'b1;
          cnt          <= '0;
          state        <= S_RUN;
        end
        // A halt seen on the last allowed cycle still counts as a clean halt.
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (bus.core_halted || cnt == T_LAST) begin
            bus.timeout   <= ~bus.core_halted;
            bus.core_run  <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= S_DUMP;
          end
        end
        S_DUMP: begin
          if (bus.out_ready) begin
            if (idx == R_LAST) begin
              bus.out_valid <= 1'b0;
              bus.done      <= 1'b1;
              state         <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: randomized programs and register
// contents checked against a simple ordered-write / ordered-dump reference.
module tb_mips_prog_loader;
  logic clk1 = 1'b0;
  logic rst  = 1'b0;
  always #5 clk1 = ~clk1;

  mips_prog_loader_if #(.MEM_AW(10)) m_if ();
  mips_prog_loader_if #(.MEM_AW(3))  s_if ();

  mips_prog_loader #(.MEM_AW(10), .DUMP_REGS(6), .TIMEOUT(50)) dut (
    .clk1(clk1), .rst(rst), .bus(m_if));
  mips_prog_loader #(.MEM_AW(3), .DUMP_REGS(6), .TIMEOUT(50)) dut_s (
    .clk1(clk1), .rst(rst), .bus(s_if));

  logic [31:0] regs [32];
  assign m_if.reg_rdata = regs[m_if.reg_raddr];
  assign s_if.reg_rdata = 32'h0;

  localparam logic [55:0] RST_EXP = {1'b1, 55'd0};

  int errors = 0;
  int checks = 0;
  int init_cnt = 0;
  logic [9:0]  wa_m [$];
  logic [31:0] wd_m [$];
  logic [2:0]  wa_s [$];
  logic [31:0] wd_s [$];
  logic [31:0] dq [$];
  logic        lq [$];

  always @(negedge clk1) begin
    if (m_if.mem_we === 1'b1) begin
      wa_m.push_back(m_if.mem_addr);
      wd_m.push_back(m_if.mem_wdata);
    end
    if (m_if.core_init === 1'b1) init_cnt++;
    if (s_if.mem_we === 1'b1) begin
      wa_s.push_back(s_if.mem_addr);
      wd_s.push_back(s_if.mem_wdata);
    end
  end

  task automatic idle_inputs();
    m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.in_last = 1'b0;
    m_if.core_halted = 1'b0; m_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.in_last = 1'b0;
    s_if.core_halted = 1'b0; s_if.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] d, input logic l, output bit acc);
    acc = 1'b0;
    m_if.in_valid = 1'b1; m_if.in_data = d; m_if.in_last = l;
    for (int t = 0; t < 6 && !acc; t++) begin
      @(negedge clk1);
      if (m_if.in_ready === 1'b1) acc = 1'b1;
      @(posedge clk1); #1;
    end
    m_if.in_valid = 1'b0; m_if.in_last = 1'b0;
  endtask

  task automatic send_s(input logic [31:0] d, input logic l, output bit acc);
    acc = 1'b0;
    s_if.in_valid = 1'b1; s_if.in_data = d; s_if.in_last = l;
    for (int t = 0; t < 6 && !acc; t++) begin
      @(negedge clk1);
      if (s_if.in_ready === 1'b1) acc = 1'b1;
      @(posedge clk1); #1;
    end
    s_if.in_valid = 1'b0; s_if.in_last = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk1);
      if (m_if.core_run === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic halt_core(output bit ok);
    @(posedge clk1); #1 m_if.core_halted = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk1);
      if (m_if.out_valid === 1'b1) begin ok = 1'b1; break; end
    end
    m_if.core_halted = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic run_dump(input int stall, output int nvalid, output int unstable, output bit to);
    logic [31:0] held;
    bit holding;
    int ph;
    held = '0; holding = 1'b0; ph = 0; nvalid = 0; unstable = 0; to = 1'b1;
    dq.delete(); lq.delete();
    for (int budget = 0; budget < 300; budget++) begin
      m_if.out_ready = (ph >= stall);
      @(negedge clk1);
      if (m_if.done === 1'b1) begin to = 1'b0; break; end
      if (m_if.out_valid === 1'b1) begin
        nvalid++;
        if (holding && m_if.out_data !== held) unstable++;
        if (m_if.out_ready) begin
          dq.push_back(m_if.out_data); lq.push_back(m_if.out_last);
          holding = 1'b0; ph = 0;
        end else begin
          held = m_if.out_data; holding = 1'b1; ph++;
        end
      end
      @(posedge clk1); #1;
    end
    m_if.out_ready = 1'b0;
    if (!to) begin @(posedge clk1); #1; end
  endtask

  task automatic test_reset();
    logic [55:0] obs;
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    obs = {m_if.in_ready, m_if.mem_we, m_if.mem_addr, m_if.mem_wdata, m_if.core_init,
           m_if.core_run, m_if.reg_raddr, m_if.out_valid, m_if.out_last, m_if.done,
           m_if.timeout, m_if.overflow};
    checks++;
    if (obs !== RST_EXP) begin errors++; $display("FAIL reset_vals: got %h expected %h", obs, RST_EXP); end
    checks++;
    if ({s_if.in_ready, s_if.mem_we, s_if.overflow, s_if.core_run} !== 4'b1000) begin
      errors++; $display("FAIL reset_small: got %b expected 1000",
                         {s_if.in_ready, s_if.mem_we, s_if.overflow, s_if.core_run});
    end
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    checks++;
    if ({m_if.in_ready, m_if.mem_we, m_if.core_run} !== 3'b100) begin
      errors++; $display("FAIL reset_idle: got %b expected 100", {m_if.in_ready, m_if.mem_we, m_if.core_run});
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_load_program();
    logic [31:0] prog [9];
    int b, ib, nacc, bad, nvalid, unstable, r;
    bit acc, to;
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    regs[0] = 0; regs[1] = 10; regs[2] = 20; regs[3] = 25; regs[4] = 30; regs[5] = 55;
    for (int i = 6; i < 32; i++) regs[i] = $urandom;
    do_reset();
    b = wa_m.size(); ib = init_cnt; nacc = 0;
    for (int i = 0; i < 9; i++) begin send_m(prog[i], (i == 8), acc); nacc += int'(acc); end
    checks++;
    if (nacc != 9) begin errors++; $display("FAIL prog_accept: got %0d expected 9", nacc); end
    @(negedge clk1);
    checks++;
    if ({m_if.core_init, m_if.core_run, m_if.mem_we, m_if.in_ready} !== 4'b1010) begin
      errors++; $display("FAIL start_state: got %b expected 1010",
                         {m_if.core_init, m_if.core_run, m_if.mem_we, m_if.in_ready});
    end
    checks++;
    if ({m_if.mem_addr, m_if.mem_wdata} !== {10'd8, 32'hfc000000}) begin
      errors++; $display("FAIL final_write: got %h/%h expected 8/fc000000", m_if.mem_addr, m_if.mem_wdata);
    end
    @(posedge clk1); #1;
    @(negedge clk1);
    checks++;
    if ({m_if.core_init, m_if.core_run} !== 2'b01) begin
      errors++; $display("FAIL run_entry: got %b expected 01", {m_if.core_init, m_if.core_run});
    end
    r = $urandom_range(0, 8);
    repeat (r) @(negedge clk1);
    @(posedge clk1); #1 m_if.core_halted = 1'b1;
    @(negedge clk1);
    checks++;
    if ({m_if.out_valid, m_if.core_run} !== 2'b01) begin
      errors++; $display("FAIL halt_sample: got %b expected 01", {m_if.out_valid, m_if.core_run});
    end
    @(posedge clk1); #1 m_if.core_halted = 1'b0;
    @(negedge clk1);
    checks++;
    if ({m_if.out_valid, m_if.core_run} !== 2'b10) begin
      errors++; $display("FAIL dump_entry: got %b expected 10", {m_if.out_valid, m_if.core_run});
    end
    @(posedge clk1); #1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (b + i >= wa_m.size()) bad++;
      else if (wa_m[b+i] !== 10'(i) || wd_m[b+i] !== prog[i]) bad++;
    end
    checks++;
    if (bad != 0 || wa_m.size() - b != 9) begin
      errors++; $display("FAIL prog_writes: got %0d writes with %0d wrong, expected 9 exact", wa_m.size() - b, bad);
    end
    checks++;
    if (init_cnt - ib != 1) begin errors++; $display("FAIL init_pulses: got %0d expected 1", init_cnt - ib); end
    run_dump(0, nvalid, unstable, to);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= dq.size()) bad++;
      else if (dq[i] !== regs[i] || lq[i] !== (i == 5)) bad++;
    checks++;
    if (to || bad != 0 || dq.size() != 6) begin
      errors++; $display("FAIL prog_dump: got %0d words %0d wrong timeout=%0d, expected 6 exact", dq.size(), bad, to);
    end
    checks++;
    if (nvalid != 6) begin errors++; $display("FAIL dump_rate: got %0d cycles expected 6", nvalid); end
    checks++;
    if ({m_if.done, m_if.timeout, m_if.overflow, m_if.out_valid, m_if.in_ready, m_if.core_run} !== 6'b100000) begin
      errors++; $display("FAIL done_state: got %b expected 100000",
        {m_if.done, m_if.timeout, m_if.overflow, m_if.out_valid, m_if.in_ready, m_if.core_run});
    end
  endtask

  task automatic test_throttled();
    logic [31:0] w [9];
    int b, nacc, bad, nvalid, unstable;
    bit acc, ok, to;
    for (int i = 0; i < 9; i++) w[i] = $urandom;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    b = wa_m.size(); nacc = 0;
    for (int i = 0; i < 9; i++) begin
      send_m(w[i], (i == 8), acc); nacc += int'(acc);
      if (i < 8) begin @(posedge clk1); #1; end
    end
    wait_run(ok);
    checks++;
    if (!ok || nacc != 9) begin errors++; $display("FAIL thr_run: got run=%0d acc=%0d expected 1/9", ok, nacc); end
    halt_core(ok);
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (b + i >= wa_m.size()) bad++;
      else if (wa_m[b+i] !== 10'(i) || wd_m[b+i] !== w[i]) bad++;
    checks++;
    if (bad != 0 || wa_m.size() - b != 9) begin
      errors++; $display("FAIL thr_writes: got %0d writes with %0d wrong, expected 9 exact", wa_m.size() - b, bad);
    end
    run_dump(0, nvalid, unstable, to);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= dq.size()) bad++;
      else if (dq[i] !== regs[i] || lq[i] !== (i == 5)) bad++;
    checks++;
    if (!ok || to || bad != 0 || dq.size() != 6 || m_if.timeout !== 1'b0) begin
      errors++; $display("FAIL thr_dump: got %0d words %0d wrong halt=%0d to=%0d tflag=%b, expected 6 exact",
                         dq.size(), bad, ok, to, m_if.timeout);
    end
  endtask

  task automatic test_timeout();
    int k, bad, nvalid, unstable;
    bit acc, ok, to;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) send_m($urandom, (i == 2), acc);
    wait_run(ok);
    k = 0;
    while (m_if.timeout !== 1'b1 && k < 200) begin @(negedge clk1); k++; end
    checks++;
    if (!ok || k != 50) begin errors++; $display("FAIL timeout_cycles: got %0d (run=%0d) expected 50", k, ok); end
    checks++;
    if ({m_if.out_valid, m_if.core_run, m_if.timeout} !== 3'b101) begin
      errors++; $display("FAIL timeout_state: got %b expected 101", {m_if.out_valid, m_if.core_run, m_if.timeout});
    end
    @(posedge clk1); #1;
    run_dump(0, nvalid, unstable, to);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= dq.size()) bad++;
      else if (dq[i] !== regs[i] || lq[i] !== (i == 5)) bad++;
    checks++;
    if (to || bad != 0 || dq.size() != 6 || {m_if.done, m_if.timeout} !== 2'b11) begin
      errors++; $display("FAIL timeout_dump: got %0d words %0d wrong done/to=%b, expected 6 exact and 11",
                         dq.size(), bad, {m_if.done, m_if.timeout});
    end
  endtask

  task automatic test_backpressure();
    int bad, nvalid, unstable;
    bit acc, ok, to;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    do_reset();
    send_m($urandom, 1'b0, acc);
    send_m($urandom, 1'b1, acc);
    wait_run(ok);
    halt_core(ok);
    run_dump(3, nvalid, unstable, to);
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= dq.size()) bad++;
      else if (dq[i] !== 32'h100 + i || lq[i] !== (i == 5)) bad++;
    checks++;
    if (!ok || to || bad != 0 || dq.size() != 6) begin
      errors++; $display("FAIL bp_dump: got %0d words %0d wrong halt=%0d to=%0d, expected 0x100..0x105", dq.size(), bad, ok, to);
    end
    checks++;
    if (nvalid != 24 || m_if.done !== 1'b1) begin
      errors++; $display("FAIL bp_done: got %0d cycles done=%b expected 24 and 1", nvalid, m_if.done);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [10];
    int b, n1, n2, bad;
    bit acc;
    for (int i = 0; i < 10; i++) w[i] = $urandom;
    do_reset();
    b = wa_s.size(); n1 = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      send_s(w[i], 1'b0, acc);
      if (i < 8) n1 += int'(acc); else n2 += int'(acc);
      if (i == 6) begin
        @(negedge clk1);
        checks++;
        if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", s_if.overflow); end
        @(posedge clk1); #1;
      end
      if (i == 7) begin
        @(negedge clk1);
        checks++;
        if ({s_if.overflow, s_if.in_ready, s_if.mem_we, s_if.mem_addr} !== 6'b101111) begin
          errors++; $display("FAIL ovf_set: got %b expected 101111",
                             {s_if.overflow, s_if.in_ready, s_if.mem_we, s_if.mem_addr});
        end
        @(posedge clk1); #1;
      end
    end
    checks++;
    if (n1 != 8 || n2 != 0) begin errors++; $display("FAIL ovf_accept: got %0d/%0d expected 8/0", n1, n2); end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (b + i >= wa_s.size()) bad++;
      else if (wa_s[b+i] !== 3'(i) || wd_s[b+i] !== w[i]) bad++;
    checks++;
    if (bad != 0 || wa_s.size() - b != 8 || s_if.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_writes: got %0d writes %0d wrong ovf=%b, expected 8 exact and 1",
                         wa_s.size() - b, bad, s_if.overflow);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w [2];
    logic [55:0] obs;
    int b, nacc;
    bit acc;
    w[0] = $urandom; w[1] = $urandom;
    do_reset();
    for (int i = 0; i < 4; i++) send_m($urandom | 32'h1, 1'b0, acc);
    @(negedge clk1);
    checks++;
    if ({m_if.mem_we, m_if.mem_addr} !== {1'b1, 10'd3}) begin
      errors++; $display("FAIL mid_pre: got %b/%0d expected 1/3", m_if.mem_we, m_if.mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    obs = {m_if.in_ready, m_if.mem_we, m_if.mem_addr, m_if.mem_wdata, m_if.core_init,
           m_if.core_run, m_if.reg_raddr, m_if.out_valid, m_if.out_last, m_if.done,
           m_if.timeout, m_if.overflow};
    checks++;
    if (obs !== RST_EXP) begin errors++; $display("FAIL mid_async: got %h expected %h", obs, RST_EXP); end
    #1 rst = 1'b0;
    @(posedge clk1); #1;
    b = wa_m.size(); nacc = 0;
    send_m(w[0], 1'b0, acc); nacc += int'(acc);
    send_m(w[1], 1'b1, acc); nacc += int'(acc);
    @(negedge clk1);
    @(posedge clk1); #1;
    checks++;
    if (nacc != 2 || wa_m.size() - b != 2) begin
      errors++; $display("FAIL mid_reload_cnt: got acc=%0d writes=%0d expected 2/2", nacc, wa_m.size() - b);
    end else begin
      checks++;
      if ({wa_m[b], wd_m[b], wa_m[b+1], wd_m[b+1]} !== {10'd0, w[0], 10'd1, w[1]}) begin
        errors++; $display("FAIL mid_reload: got %0d:%h %0d:%h expected 0:%h 1:%h",
                           wa_m[b], wd_m[b], wa_m[b+1], wd_m[b+1], w[0], w[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_load_program();
    test_throttled();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "global timeout");
  end

endmodule
